// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with load, clamp, optional wrap,
// terminal-count pulse and cascade borrow.
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                load,
  input  logic                en,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                borrow_out,
  output logic                done,
  output logic                wrapped
);

  logic [4*DIGITS-1:0] d_clamped;
  logic [4*DIGITS-1:0] q_dec;
  logic                is_one;
  logic                hit_zero;

  // Per-digit load clamp and ripple-borrow decrement; digit i only moves
  // when every lower digit is zero, so all-zero decrements to all-nines.
  always_comb begin
    logic chain;
    d_clamped = '0;
    q_dec     = '0;
    chain     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d_clamped[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd9 : d[4*i +: 4];
      if (chain)
        q_dec[4*i +: 4] = (q[4*i +: 4] == 4'd0) ? 4'd9 : q[4*i +: 4] - 4'd1;
      else
        q_dec[4*i +: 4] = q[4*i +: 4];
      chain = chain && (q[4*i +: 4] == 4'd0);
    end
  end

  assign zero       = (q == '0);
  assign is_one     = (q == (4*DIGITS)'(1));
  assign borrow_out = en & zero & ~load;

  // hit_zero marks the edge where a decrement lands on zero; done follows it
  // one edge later so the pulse sits in the cycle after q first reads zero.
  always_ff @(posedge clk) begin
    if (!clr) begin
      q        <= '0;
      done     <= 1'b0;
      wrapped  <= 1'b0;
      hit_zero <= 1'b0;
    end else if (load) begin
      q        <= d_clamped;
      done     <= 1'b0;
      wrapped  <= 1'b0;
      hit_zero <= 1'b0;
    end else begin
      done     <= hit_zero;
      hit_zero <= en && is_one;
      if (en) begin
        if (!zero) begin
          q <= q_dec;
        end else if (WRAP) begin
          q       <= q_dec;
          wrapped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter: wrap, hold and cascaded
// single-digit instances driven with hand-computed vectors.
module tb_bcd_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Two-digit wrapping instance
  logic       w_clr, w_load, w_en;
  logic [7:0] w_d, w_q;
  logic       w_zero, w_borrow, w_done, w_wrapped;

  // Two-digit stop-at-zero instance
  logic       h_clr, h_load, h_en;
  logic [7:0] h_d, h_q;
  logic       h_zero, h_borrow, h_done, h_wrapped;

  // Cascaded single-digit pair
  logic       c_clr, c_load, c_en;
  logic [3:0] lo_d, lo_q, hi_d, hi_q;
  logic       lo_zero, lo_borrow, lo_done, lo_wrapped;
  logic       hi_zero, hi_borrow, hi_done, hi_wrapped;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .clr(w_clr), .load(w_load), .en(w_en), .d(w_d), .q(w_q),
    .zero(w_zero), .borrow_out(w_borrow), .done(w_done), .wrapped(w_wrapped));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_h (
    .clk(clk), .clr(h_clr), .load(h_load), .en(h_en), .d(h_d), .q(h_q),
    .zero(h_zero), .borrow_out(h_borrow), .done(h_done), .wrapped(h_wrapped));

  bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) dut_lo (
    .clk(clk), .clr(c_clr), .load(c_load), .en(c_en), .d(lo_d), .q(lo_q),
    .zero(lo_zero), .borrow_out(lo_borrow), .done(lo_done), .wrapped(lo_wrapped));

  bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) dut_hi (
    .clk(clk), .clr(c_clr), .load(c_load), .en(lo_borrow), .d(hi_d), .q(hi_q),
    .zero(hi_zero), .borrow_out(hi_borrow), .done(hi_done), .wrapped(hi_wrapped));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    w_clr = 1'b0; w_load = 1'b1; w_en = 1'b1; w_d = 8'h57;
    h_clr = 1'b0; h_load = 1'b1; h_en = 1'b1; h_d = 8'h57;
    c_clr = 1'b0; c_load = 1'b1; c_en = 1'b1; lo_d = 4'h5; hi_d = 4'h7;
    step();
    step();
    checks++; if (w_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q got=%h exp=00", w_q); end
    checks++; if (w_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", w_done); end
    checks++; if (w_wrapped !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrapped got=%b exp=0", w_wrapped); end
    checks++; if (w_zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero got=%b exp=1", w_zero); end
    checks++; if (w_borrow !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow_with_load got=%b exp=0", w_borrow); end
    checks++; if (h_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_hold_q got=%h exp=00", h_q); end
    checks++; if (hi_q !== 4'h0 || lo_q !== 4'h0) begin errors++; $display("[TB] FAIL reset_cascade got=%h%h exp=00", hi_q, lo_q); end
    w_clr = 1'b1; w_load = 1'b0; w_en = 1'b0;
    h_clr = 1'b1; h_load = 1'b0; h_en = 1'b0;
    c_clr = 1'b1; c_load = 1'b0; c_en = 1'b0;
  endtask

  task automatic test_count();
    logic [7:0] exp_q [12];
    exp_q = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
              8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    w_load = 1'b1; w_en = 1'b0; w_d = 8'h12;
    step();
    checks++; if (w_q !== 8'h12) begin errors++; $display("[TB] FAIL count_load got=%h exp=12", w_q); end
    w_load = 1'b0; w_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (w_q !== exp_q[k]) begin errors++; $display("[TB] FAIL count_q[%0d] got=%h exp=%h", k, w_q, exp_q[k]); end
      checks++; if (w_done !== 1'b0) begin errors++; $display("[TB] FAIL count_done_early[%0d] got=%b exp=0", k, w_done); end
    end
    checks++; if (w_zero !== 1'b1 || w_borrow !== 1'b1) begin errors++; $display("[TB] FAIL count_zero_borrow got=%b%b exp=11", w_zero, w_borrow); end
    step();
    checks++; if (w_done !== 1'b1) begin errors++; $display("[TB] FAIL count_done_pulse got=%b exp=1", w_done); end
    checks++; if (w_q !== 8'h99 || w_wrapped !== 1'b1) begin errors++; $display("[TB] FAIL count_wrap got=%h/%b exp=99/1", w_q, w_wrapped); end
    w_en = 1'b0;
    step();
    checks++; if (w_done !== 1'b0) begin errors++; $display("[TB] FAIL count_done_one_cycle got=%b exp=0", w_done); end
    checks++; if (w_q !== 8'h99 || w_wrapped !== 1'b1) begin errors++; $display("[TB] FAIL count_hold got=%h/%b exp=99/1", w_q, w_wrapped); end
  endtask

  task automatic test_digit_borrow();
    w_load = 1'b1; w_en = 1'b0; w_d = 8'h40;
    step();
    checks++; if (w_q !== 8'h40 || w_wrapped !== 1'b0) begin errors++; $display("[TB] FAIL borrow_load got=%h/%b exp=40/0", w_q, w_wrapped); end
    w_load = 1'b0; w_en = 1'b1;
    step();
    checks++; if (w_q !== 8'h39) begin errors++; $display("[TB] FAIL borrow_40 got=%h exp=39", w_q); end
    w_load = 1'b1; w_en = 1'b0; w_d = 8'h00;
    step();
    checks++; if (w_q !== 8'h00 || w_done !== 1'b0) begin errors++; $display("[TB] FAIL borrow_load0 got=%h/%b exp=00/0", w_q, w_done); end
    w_load = 1'b0; w_en = 1'b1;
    step();
    checks++; if (w_q !== 8'h99 || w_wrapped !== 1'b1 || w_done !== 1'b0) begin errors++; $display("[TB] FAIL borrow_wrap got=%h/%b/%b exp=99/1/0", w_q, w_wrapped, w_done); end
    w_en = 1'b0;
    step();
    checks++; if (w_done !== 1'b0) begin errors++; $display("[TB] FAIL borrow_wrap_nodone got=%b exp=0", w_done); end
  endtask

  task automatic test_hold();
    logic [7:0] exp_q [5];
    logic       exp_done [5];
    exp_q    = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    h_load = 1'b1; h_en = 1'b0; h_d = 8'h02;
    step();
    h_load = 1'b0; h_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (h_q !== exp_q[k]) begin errors++; $display("[TB] FAIL hold_q[%0d] got=%h exp=%h", k, h_q, exp_q[k]); end
      checks++; if (h_done !== exp_done[k]) begin errors++; $display("[TB] FAIL hold_done[%0d] got=%b exp=%b", k, h_done, exp_done[k]); end
      checks++; if (h_wrapped !== 1'b0) begin errors++; $display("[TB] FAIL hold_wrapped[%0d] got=%b exp=0", k, h_wrapped); end
    end
    h_en = 1'b0;
  endtask

  task automatic test_clamp_priority();
    w_load = 1'b1; w_en = 1'b1; w_d = 8'hAF;
    step();
    checks++; if (w_q !== 8'h99) begin errors++; $display("[TB] FAIL clamp_AF got=%h exp=99", w_q); end
    w_d = 8'h3C;
    step();
    checks++; if (w_q !== 8'h39) begin errors++; $display("[TB] FAIL clamp_3C got=%h exp=39", w_q); end
    w_d = 8'hB4;
    step();
    checks++; if (w_q !== 8'h94) begin errors++; $display("[TB] FAIL clamp_B4 got=%h exp=94", w_q); end
    w_clr = 1'b0; w_d = 8'h57;
    step();
    checks++; if (w_q !== 8'h00) begin errors++; $display("[TB] FAIL clr_over_load got=%h exp=00", w_q); end
    w_clr = 1'b1; w_load = 1'b1; w_en = 1'b0; w_d = 8'h01;
    step();
    w_load = 1'b0; w_en = 1'b1;
    step();
    w_clr = 1'b0; w_en = 1'b0;
    step();
    checks++; if (w_q !== 8'h00 || w_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_kills_done got=%h/%b exp=00/0", w_q, w_done); end
    w_clr = 1'b1;
    step();
    checks++; if (w_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_no_residual got=%b exp=0", w_done); end
  endtask

  task automatic test_cascade();
    c_load = 1'b1; c_en = 1'b0; lo_d = 4'h0; hi_d = 4'h3;
    step();
    checks++; if (hi_q !== 4'h3 || lo_q !== 4'h0) begin errors++; $display("[TB] FAIL cas_load got=%h%h exp=30", hi_q, lo_q); end
    c_load = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 1) begin
        checks++; if (hi_q !== 4'h2 || lo_q !== 4'h9 || lo_wrapped !== 1'b1) begin errors++; $display("[TB] FAIL cas_e1 got=%h%h/%b exp=29/1", hi_q, lo_q, lo_wrapped); end
      end else if (k == 2) begin
        checks++; if (hi_q !== 4'h2 || lo_q !== 4'h8) begin errors++; $display("[TB] FAIL cas_e2 got=%h%h exp=28", hi_q, lo_q); end
      end else if (k == 10) begin
        checks++; if (hi_q !== 4'h2 || lo_q !== 4'h0 || lo_borrow !== 1'b1) begin errors++; $display("[TB] FAIL cas_e10 got=%h%h/%b exp=20/1", hi_q, lo_q, lo_borrow); end
      end else if (k == 11) begin
        checks++; if (hi_q !== 4'h1 || lo_q !== 4'h9) begin errors++; $display("[TB] FAIL cas_e11 got=%h%h exp=19", hi_q, lo_q); end
      end else if (k == 21) begin
        checks++; if (hi_q !== 4'h0 || lo_q !== 4'h9 || hi_done !== 1'b0) begin errors++; $display("[TB] FAIL cas_e21 got=%h%h/%b exp=09/0", hi_q, lo_q, hi_done); end
      end else if (k == 22) begin
        checks++; if (hi_q !== 4'h0 || lo_q !== 4'h8 || hi_done !== 1'b1) begin errors++; $display("[TB] FAIL cas_e22 got=%h%h/%b exp=08/1", hi_q, lo_q, hi_done); end
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_digit_borrow();
    test_hold();
    test_clamp_priority();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
